// File: rtl/enemy_sprite_fetch_pkg.sv
// Shared enemy sprite geometry, transparency key and colour word types.
package enemy_sprite_fetch_pkg;

  localparam int unsigned SPR_W     = 64;
  localparam int unsigned SPR_H     = 42;
  localparam int unsigned FRAMES    = 4;
  localparam int unsigned FRAME_PIX = SPR_W * SPR_H;
  localparam int unsigned RGB_W     = 12;
  localparam int unsigned ANIM_DIV  = 8;

  localparam logic [RGB_W-1:0] KEY_COLOR = 12'h0F0;

  typedef logic [RGB_W-1:0] rgb444_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pix_pos_t;

endpackage

// File: rtl/enemy_anim_ctr.sv
// Animation frame counter: advances frame_idx once every ANIM_DIV frame ticks.
module enemy_anim_ctr #(
  parameter int unsigned FRAMES   = enemy_sprite_fetch_pkg::FRAMES,
  parameter int unsigned ANIM_DIV = enemy_sprite_fetch_pkg::ANIM_DIV
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_frame_tick,
  input  logic                      i_anim_en,
  output logic [$clog2(FRAMES)-1:0] o_frame_idx
);

  localparam int unsigned DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned FIDX_W = $clog2(FRAMES);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [FIDX_W-1:0] r_frame_idx;

  // Only the tick edge moves the frame, so a whole video frame sees one index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_frame_idx <= '0;
    end else if (i_frame_tick && i_anim_en) begin
      if (r_div_cnt == DIV_W'(ANIM_DIV - 1)) begin
        r_div_cnt   <= '0;
        r_frame_idx <= (r_frame_idx == FIDX_W'(FRAMES - 1)) ? '0
                                                             : r_frame_idx + FIDX_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  assign o_frame_idx = r_frame_idx;

endmodule

// File: rtl/enemy_sprite_fetch.sv
// Enemy sprite reader: box test and ROM addressing, ROM latency alignment,
// and colour-key removal, three clocks from pixel sample to colour out.
module enemy_sprite_fetch #(
  parameter int unsigned            SPR_W      = enemy_sprite_fetch_pkg::SPR_W,
  parameter int unsigned            SPR_H      = enemy_sprite_fetch_pkg::SPR_H,
  parameter int unsigned            FRAMES     = enemy_sprite_fetch_pkg::FRAMES,
  parameter int unsigned            ADDR_WIDTH = 14,
  parameter int unsigned            DATA_WIDTH = enemy_sprite_fetch_pkg::RGB_W,
  parameter logic [DATA_WIDTH-1:0]  KEY_COLOR  = enemy_sprite_fetch_pkg::KEY_COLOR,
  parameter int unsigned            ANIM_DIV   = enemy_sprite_fetch_pkg::ANIM_DIV
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      pixel_valid,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  input  logic                      visible,
  input  logic                      flip_x,
  input  logic                      anim_en,
  input  logic                      frame_tick,
  output logic [ADDR_WIDTH-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  output logic [DATA_WIDTH-1:0]     rgb_o,
  output logic                      opaque_o,
  output logic [$clog2(FRAMES)-1:0] frame_idx
);

  import enemy_sprite_fetch_pkg::*;

  localparam int unsigned DX_W        = $clog2(SPR_W);
  localparam int unsigned DY_W        = $clog2(SPR_H);
  localparam int unsigned FIDX_W      = $clog2(FRAMES);
  localparam int unsigned FRAME_WORDS = SPR_W * SPR_H;

  pix_pos_t              w_pix;
  pix_pos_t              w_pos;
  logic [10:0]           w_px, w_py, w_ox, w_oy;
  logic                  w_in_box;
  logic [DX_W-1:0]       w_dx_raw;
  logic [DX_W-1:0]       w_dx;
  logic [DY_W-1:0]       w_dy;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [FIDX_W-1:0]     w_frame_idx;
  logic                  w_opaque;

  logic                  r_in_box_d1;
  logic                  r_in_box_d2;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_rgb;
  logic                  r_opaque;

  assign w_pix = '{x: pixel_x, y: pixel_y};
  assign w_pos = '{x: pos_x,   y: pos_y};

  // 11-bit compare so a box near the right/bottom edge cannot wrap.
  assign w_px = {1'b0, w_pix.x};
  assign w_py = {1'b0, w_pix.y};
  assign w_ox = {1'b0, w_pos.x};
  assign w_oy = {1'b0, w_pos.y};

  assign w_in_box = pixel_valid & visible
                  & (w_px >= w_ox) & (w_px < w_ox + 11'(SPR_W))
                  & (w_py >= w_oy) & (w_py < w_oy + 11'(SPR_H));

  assign w_dx_raw = DX_W'(w_pix.x - w_pos.x);
  assign w_dy     = DY_W'(w_pix.y - w_pos.y);
  assign w_dx     = flip_x ? (DX_W'(SPR_W - 1) - w_dx_raw) : w_dx_raw;

  assign w_addr = ADDR_WIDTH'(32'(w_frame_idx) * FRAME_WORDS)
                + (ADDR_WIDTH'(w_dy) << DX_W)
                + ADDR_WIDTH'(w_dx);

  assign w_opaque = r_in_box_d2 && (rom_data != KEY_COLOR);

  enemy_anim_ctr #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV)
  ) u_anim_ctr (
    .clk          (clk),
    .reset        (reset),
    .i_frame_tick (frame_tick),
    .i_anim_en    (anim_en),
    .o_frame_idx  (w_frame_idx)
  );

  // Stage 1 address, stage 2 flag alongside ROM read, stage 3 keyed colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr  <= '0;
      r_in_box_d1 <= 1'b0;
      r_in_box_d2 <= 1'b0;
      r_rgb       <= '0;
      r_opaque    <= 1'b0;
    end else begin
      r_rom_addr  <= w_in_box ? w_addr : '0;
      r_in_box_d1 <= w_in_box;
      r_in_box_d2 <= r_in_box_d1;
      r_opaque    <= w_opaque;
      r_rgb       <= w_opaque ? rom_data : '0;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rgb_o     = r_rgb;
  assign opaque_o  = r_opaque;
  assign frame_idx = w_frame_idx;

endmodule

// File: tb/tb_enemy_sprite_fetch.sv
// Scoreboard bench for enemy_sprite_fetch with a behavioural 1-cycle sprite ROM.
module tb_enemy_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y, pos_x, pos_y;
  logic        pixel_valid, visible, flip_x, anim_en, frame_tick;
  logic [13:0] rom_addr;
  logic [11:0] rom_data, rgb_o;
  logic        opaque_o;
  logic [1:0]  frame_idx;

  logic [11:0] mem [0:10751];
  logic [11:0] rom_q;
  logic        force_fff;

  typedef struct packed {
    logic [11:0] rgb;
    logic        op;
  } out_t;

  logic [13:0] q_addr [$];
  out_t        q_out  [$];
  logic        issue;
  logic        d1, d2, d3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enemy_sprite_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .visible     (visible),
    .flip_x      (flip_x),
    .anim_en     (anim_en),
    .frame_tick  (frame_tick),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rgb_o       (rgb_o),
    .opaque_o    (opaque_o),
    .frame_idx   (frame_idx)
  );

  always @(posedge clk) rom_q <= mem[rom_addr];
  assign rom_data = force_fff ? 12'hFFF : rom_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
    end else begin
      d1 <= issue; d2 <= d1; d3 <= d2;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: rom_addr one clock after a pixel, colour three clocks after.
  always @(negedge clk) begin : monitor
    logic [13:0] ea;
    out_t        eo;
    if (!reset) begin
      if (d1) begin
        if (q_addr.size() == 0) check("addr_queue_underflow", 32'd1, 32'd0);
        else begin
          ea = q_addr.pop_front();
          check("rom_addr", 32'(rom_addr), 32'(ea));
        end
      end
      if (d3) begin
        if (q_out.size() == 0) check("out_queue_underflow", 32'd1, 32'd0);
        else begin
          eo = q_out.pop_front();
          check("rgb_o", 32'(rgb_o), 32'(eo.rgb));
          check("opaque_o", 32'(opaque_o), 32'(eo.op));
        end
      end
    end
  end

  task automatic px(input int x, input int y, input int ox, input int oy,
                    input bit fl, input bit vis, input bit val,
                    input int ea, input bit eop);
    out_t e;
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y);
    pos_x = 10'(ox);  pos_y = 10'(oy);
    flip_x = fl; visible = vis; pixel_valid = val;
    issue = 1'b1;
    e.rgb = eop ? mem[ea] : 12'h000;
    e.op  = eop;
    q_addr.push_back(14'(ea));
    q_out.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      issue = 1'b0; pixel_valid = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      issue = 1'b0; pixel_valid = 1'b0; frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 10752; a++) mem[a] = 12'h800 | 12'(a);
    mem[5] = 12'h0F0;
    reset = 1'b1; force_fff = 1'b0; issue = 1'b0;
    pixel_x = '0; pixel_y = '0; pos_x = 10'd100; pos_y = 10'd50;
    pixel_valid = 1'b0; visible = 1'b1; flip_x = 1'b0;
    anim_en = 1'b0; frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("reset_rgb", 32'(rgb_o), 32'd0);
    check("reset_opaque", 32'(opaque_o), 32'd0);
    check("reset_frame", 32'(frame_idx), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);

    // x, y, pos_x, pos_y, flip, visible, valid, expected addr, expected opaque
    px(100, 50, 100, 50, 0, 1, 1,    0, 1);
    px(163, 91, 100, 50, 0, 1, 1, 2687, 1);
    px(164, 91, 100, 50, 0, 1, 1,    0, 0);
    px( 99, 50, 100, 50, 0, 1, 1,    0, 0);
    px(100, 50, 100, 50, 1, 1, 1,   63, 1);
    px(163, 91, 100, 50, 1, 1, 1, 2624, 1);
    px(105, 50, 100, 50, 0, 1, 1,    5, 0);
    px(1020, 50, 1000, 50, 0, 1, 1,  20, 1);
    px(  5, 50, 1000, 50, 0, 1, 1,   0, 0);
    px(110, 60, 100, 50, 0, 0, 1,    0, 0);
    px(110, 60, 100, 50, 0, 1, 0,    0, 0);
    px(110, 60, 100, 50, 0, 1, 1,  650, 1);
    px(100, 92, 100, 50, 0, 1, 1,    0, 0);
    px(100, 49, 100, 50, 0, 1, 1,    0, 0);
    idle(4);

    anim_en = 1'b1;
    ticks(7);
    check("frame_after_7", 32'(frame_idx), 32'd0);
    ticks(1);
    check("frame_after_8", 32'(frame_idx), 32'd1);
    px(100, 50, 100, 50, 0, 1, 1, 2688, 1);
    idle(4);
    ticks(24);
    check("frame_after_32", 32'(frame_idx), 32'd0);
    ticks(8);
    check("frame_after_40", 32'(frame_idx), 32'd1);
    anim_en = 1'b0;
    ticks(20);
    check("frame_frozen", 32'(frame_idx), 32'd1);
    px(163, 91, 100, 50, 0, 1, 1, 5375, 1);
    idle(4);

    // Reset asserted mid-stream while the ROM presents an opaque word.
    force_fff = 1'b1;
    @(negedge clk);
    pixel_x = 10'd110; pixel_y = 10'd60; pos_x = 10'd100; pos_y = 10'd50;
    flip_x = 1'b0; visible = 1'b1; pixel_valid = 1'b1; issue = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_opaque", 32'(opaque_o), 32'd1);
    check("pre_reset_rgb", 32'(rgb_o), 32'hFFF);
    #2 reset = 1'b1;
    #1;
    check("async_reset_rgb", 32'(rgb_o), 32'd0);
    check("async_reset_opaque", 32'(opaque_o), 32'd0);
    check("async_reset_frame", 32'(frame_idx), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("release_rgb_0", 32'(rgb_o), 32'd0);
    check("release_opaque_0", 32'(opaque_o), 32'd0);
    @(negedge clk);
    check("release_rgb_1", 32'(rgb_o), 32'd0);
    check("release_opaque_1", 32'(opaque_o), 32'd0);
    @(negedge clk);
    check("release_rgb_2", 32'(rgb_o), 32'd0);
    check("release_opaque_2", 32'(opaque_o), 32'd0);
    @(negedge clk);
    check("release_rgb_3", 32'(rgb_o), 32'hFFF);
    check("release_opaque_3", 32'(opaque_o), 32'd1);
    force_fff = 1'b0;
    idle(4);

    check("addr_queue_drained", 32'(q_addr.size()), 32'd0);
    check("out_queue_drained", 32'(q_out.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
